alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and result stage that shares one combinational `alu` instance between two requesters, for example the integer pipeline and a debug/test port. Each requester presents an operation with a valid/ready handshake. The arbiter grants one request per cycle in round-robin order and registers the ALU result together with the owner ID. The result is returned on that owner's response channel, with back-pressure.

## Interface
- `WIDTH`, default 8: operand and result width; must match the `alu` instance.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 2: per-requester request valid; bit i = requester i.
- `req_ready` output 2: per-requester request accepted this cycle.
- `req_control0`, `req_control1` input 4 each: ALU control code per requester.
- `req_a0`, `req_a1`, `req_b0`, `req_b1` input WIDTH each: operands per requester.
- `rsp_valid` output 2: result valid for requester i.
- `rsp_ready` input 2: requester i accepts its result.
- `rsp_out` output WIDTH: registered ALU result, shared by both response channels.
- `rsp_carry` output 1: registered carry flag.
- `rsp_zero` output 1: registered zero flag.
- `rsp_err` output 1: registered flag; 1 when the control code is not one of the nine defined ALU operations.

## Operation
- **Result stage:** one entry holding `out`, `carry`, `zero`, `err` and `owner` (1 bit).
- **FSM states:** EMPTY, HELD.
- **Drain condition:** `drain` = HELD & `rsp_ready[owner]`.
- **Accept condition:** `can_accept` = EMPTY | `drain`.
- **Grant:** round-robin over `req_valid`. Register `last` records the most recent accepted requester.
  - If both requesters are valid, grant the requester ≠ `last`.
  - If only one is valid, grant it.
  - `last` updates only on an accepted request.
- **Ready:** `req_ready[i]` = `can_accept` & `grant[i]`. It is combinational from `req_valid`, `rsp_ready` and state. At most one bit is high.
- **Datapath:** a mux selects the granted requester's control and operands into the `alu`.
- **Capture:** on accept, capture the ALU outputs plus `err` and `owner` = i. Next state is HELD.
- **Drain without accept:** next state is EMPTY.
- **Simultaneous drain and accept:** the stage reloads and stays HELD, giving one result per cycle.
- **Response valid:** `rsp_valid[owner]` = HELD. The other bit is 0.
- **Hold while stalled:** while HELD and not drained, all `rsp_*` outputs hold stable and `req_ready` = 0.
- **Illegal control codes:** the ALU output (0, zero = 1) passes through and `err` = 1. This is not a protocol error.
- **Requester rule:** a requester holds valid, control and operands stable until ready. The arbiter does not check this.
- **Reset (async, any time):**
  - state EMPTY, `last` = 1 (so requester 0 wins the first conflict);
  - `rsp_out` = 0, `rsp_carry` = 0, `rsp_zero` = 0, `rsp_err` = 0, `owner` = 0;
  - `rsp_valid` = 00, `req_ready` = 00.
  - An in-flight result is dropped with no response.

## Timing
- Latency: request accepted at edge N → `rsp_valid` high after edge N, i.e. 1 cycle.
- Throughput: 1 op/cycle when the owner holds `rsp_ready` = 1.
- Fairness: with both requesters continuously valid and never stalled, grants alternate 0,1,0,1…
- Combinational paths:
  - `rsp_ready` → `req_ready` (allowed);
  - `req_valid` → `req_ready` (allowed);
  - no path `req_*` → `rsp_*`.
- First `req_ready` can be high in the first cycle after `rst` deasserts.

## Structure
- Shared package `alu_pkg`:
  - control code constants `AND`=0000, `OR`=0001, `ADD`=0010, `SLL`=0011, `XOR`=0100, `SRL`=0101, `SUB`=0110, `SRA`=0111, `SLT`=1000;
  - function `is_legal_op(control)`;
  - FSM state encoding.
- One sub-module: `alu`, instantiated once with `WIDTH` passed through.
- Round-robin grant logic stays inline; no separate module.

## Test plan
- **ADD with carry:** reset, then req0 ADD a=200, b=100 → next cycle `rsp_valid`=01, `rsp_out`=44, `rsp_carry`=1, `rsp_zero`=0, `rsp_err`=0.
- **Conflict and alternation:** req0 and req1 both valid in the same cycle (req0 SUB 5-5, req1 OR 0x0F|0xF0), `rsp_ready`=11.
  - Cycle 1: `req_ready`=01.
  - Cycle 2: `rsp_valid`=01, `rsp_out`=0, `zero`=1, `carry`=0; `req_ready`=10.
  - Cycle 3: `rsp_valid`=10, `rsp_out`=0xFF.
- **Back-pressure:** req0 SLL a=0x81, b=1, with `rsp_ready[0]`=0 for 3 cycles → `rsp_out`=0x02 held stable and `req_ready`=00 throughout. When `rsp_ready[0]` rises, a pending req1 is accepted in the same cycle.
- **Illegal code:** req1 control=1111 → `rsp_valid`=10, `rsp_out`=0, `rsp_zero`=1, `rsp_err`=1.
- **SRA/SLT sanity:** SRA a=0x80, b=3 → 0xF0; SLT a=0xFF, b=0x01 → 0x01.
- **Reset mid-hold:** assert `rst` while HELD with `rsp_ready`=0 → all outputs 0 in the same cycle. After release, no stale response; the next conflict grants req0 first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its arbiter: control codes, legality
// check and the result-stage state encoding.
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] AND = 4'b0000;
  localparam logic [CTRL_W-1:0] OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] SLL = 4'b0011;
  localparam logic [CTRL_W-1:0] XOR = 4'b0100;
  localparam logic [CTRL_W-1:0] SRL = 4'b0101;
  localparam logic [CTRL_W-1:0] SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] SRA = 4'b0111;
  localparam logic [CTRL_W-1:0] SLT = 4'b1000;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  // Codes are contiguous from AND up to SLT, so legality is a range check.
  function automatic logic is_legal_op(input logic [CTRL_W-1:0] control);
    return (control <= SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: nine operations, carry from ADD (carry out) and SUB
// (borrow), zero flag on the result. Undefined codes yield 0.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [CTRL_W-1:0] control_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              carry_o,
  output logic              zero_o
);

  logic [WIDTH-1:0] result;
  logic             carry;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (control_i)
      AND: result = a_i & b_i;
      OR:  result = a_i | b_i;
      ADD: {carry, result} = {1'b0, a_i} + {1'b0, b_i};
      SLL: result = a_i << b_i;
      XOR: result = a_i ^ b_i;
      SRL: result = a_i >> b_i;
      SUB: {carry, result} = {1'b0, a_i} - {1'b0, b_i};
      SRA: result = WIDTH'($signed(a_i) >>> b_i);
      SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

  assign out_o   = result;
  assign carry_o = carry;
  assign zero_o  = ~|result;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters, with a single-entry
// registered result stage returned on the owner's response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [CTRL_W-1:0] req_control0,
  input  logic [CTRL_W-1:0] req_control1,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_out,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              rsp_err
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  logic [1:0]        grant;
  logic              sel;
  logic              drain;
  logic              can_accept;
  logic              accept;
  logic [CTRL_W-1:0] alu_control;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic [WIDTH-1:0]  alu_out;
  logic              alu_carry;
  logic              alu_zero;

  // On a conflict the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign sel        = grant[1];
  assign drain      = (state_q == HELD) && rsp_ready[owner_q];
  assign can_accept = (state_q == EMPTY) || drain;
  assign accept     = can_accept && (|grant) && !rst;
  assign req_ready  = (can_accept && !rst) ? grant : 2'b00;

  assign alu_control = sel ? req_control1 : req_control0;
  assign alu_a       = sel ? req_a1 : req_a0;
  assign alu_b       = sel ? req_b1 : req_b0;

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .control_i(alu_control),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .out_o    (alu_out),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    rsp_valid_d = rsp_valid_q;
    out_d       = out_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    err_d       = err_q;
    if (accept) begin
      // Covers both a fresh load and a reload in the same cycle as a drain.
      state_d     = HELD;
      last_d      = sel;
      owner_d     = sel;
      rsp_valid_d = sel ? 2'b10 : 2'b01;
      out_d       = alu_out;
      carry_d     = alu_carry;
      zero_d      = alu_zero;
      err_d       = !is_legal_op(alu_control);
    end else if (drain) begin
      state_d     = EMPTY;
      rsp_valid_d = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      out_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      out_q       <= out_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = out_q;
  assign rsp_carry = carry_q;
  assign rsp_zero  = zero_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized
// run against a cycle-level behavioural model of arbitration and the ALU.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_control0, req_control1;
  logic [7:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready;
  logic [7:0] rsp_out;
  logic       rsp_carry, rsp_zero, rsp_err;

  int passed = 0;
  int total  = 0;

  alu_arbiter #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_control0(req_control0),
    .req_control1(req_control1),
    .req_a0      (req_a0),
    .req_a1      (req_a1),
    .req_b0      (req_b0),
    .req_b1      (req_b1),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_out     (rsp_out),
    .rsp_carry   (rsp_carry),
    .rsp_zero    (rsp_zero),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_control0 = 4'd0; req_control1 = 4'd0;
    req_a0 = 8'd0; req_a1 = 8'd0; req_b0 = 8'd0; req_b1 = 8'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference ALU from the operation definitions, 8-bit, plain integers.
  function automatic void ref_alu(input int ctrl, input int a, input int b,
                                  output int out, output bit carry, output bit err);
    int s, sa, sb;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    out = 0; carry = 1'b0; err = 1'b0;
    case (ctrl)
      0: out = a & b;
      1: out = a | b;
      2: begin s = a + b; out = s % 256; carry = (s > 255); end
      3: out = (b >= 8) ? 0 : ((a << b) & 255);
      4: out = a ^ b;
      5: out = (b >= 8) ? 0 : (a >> b);
      6: begin out = (a - b + 256) % 256; carry = (a < b); end
      7: out = ((b >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> b)) & 255;
      8: out = (sa < sb) ? 1 : 0;
      default: begin out = 0; err = 1'b1; end
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_out, rsp_carry, rsp_zero, rsp_err} !== 15'd0) begin
      $display("FAIL reset_outputs: got ready=%b valid=%b out=%h c=%b z=%b e=%b, want all 0",
               req_ready, rsp_valid, rsp_out, rsp_carry, rsp_zero, rsp_err);
    end else passed++;
    do_reset();
    #1;
    total++;
    if ({req_ready, rsp_valid} !== 4'b0000) begin
      $display("FAIL reset_idle: got ready=%b valid=%b, want 00 00", req_ready, rsp_valid);
    end else passed++;
    $display("test_reset done");
  endtask

  task automatic test_add_carry();
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b01; req_control0 = 4'b0010; req_a0 = 8'd200; req_b0 = 8'd100;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL add_ready: got %b want 01", req_ready);
    else passed++;
    tick();
    req_valid = 2'b00;
    #1;
    total++;
    if ({rsp_valid, rsp_out, rsp_carry, rsp_zero, rsp_err} !== {2'b01, 8'd44, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL add_result: got valid=%b out=%0d c=%b z=%b e=%b, want 01 44 1 0 0",
               rsp_valid, rsp_out, rsp_carry, rsp_zero, rsp_err);
    end else passed++;
    tick();
    total++;
    if (rsp_valid !== 2'b00) $display("FAIL add_drain: got valid=%b want 00", rsp_valid);
    else passed++;
    $display("test_add_carry done");
  endtask

  task automatic test_conflict();
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    req_control0 = 4'b0110; req_a0 = 8'd5; req_b0 = 8'd5;
    req_control1 = 4'b0001; req_a1 = 8'h0F; req_b1 = 8'hF0;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL conflict_c1_ready: got %b want 01", req_ready);
    else passed++;
    tick();
    req_valid = 2'b10;
    #1;
    total++;
    if ({rsp_valid, rsp_out, rsp_zero, rsp_carry, req_ready} !== {2'b01, 8'h00, 1'b1, 1'b0, 2'b10}) begin
      $display("FAIL conflict_c2: got valid=%b out=%h z=%b c=%b ready=%b, want 01 00 1 0 10",
               rsp_valid, rsp_out, rsp_zero, rsp_carry, req_ready);
    end else passed++;
    tick();
    req_valid = 2'b00;
    #1;
    total++;
    if ({rsp_valid, rsp_out} !== {2'b10, 8'hFF}) begin
      $display("FAIL conflict_c3: got valid=%b out=%h, want 10 ff", rsp_valid, rsp_out);
    end else passed++;
    tick();
    $display("test_conflict done");
  endtask

  task automatic test_back_pressure();
    rsp_ready = 2'b00;
    req_valid = 2'b01; req_control0 = 4'b0011; req_a0 = 8'h81; req_b0 = 8'd1;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL bp_accept: got %b want 01", req_ready);
    else passed++;
    tick();
    req_valid = 2'b10; req_control1 = 4'b0010; req_a1 = 8'd1; req_b1 = 8'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({rsp_valid, rsp_out, req_ready} !== {2'b01, 8'h02, 2'b00}) begin
        $display("FAIL bp_hold%0d: got valid=%b out=%h ready=%b, want 01 02 00",
                 i, rsp_valid, rsp_out, req_ready);
      end else passed++;
      tick();
    end
    rsp_ready = 2'b01;
    #1;
    total++;
    if (req_ready !== 2'b10) $display("FAIL bp_release_ready: got %b want 10", req_ready);
    else passed++;
    tick();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    #1;
    total++;
    if ({rsp_valid, rsp_out} !== {2'b10, 8'd3}) begin
      $display("FAIL bp_next: got valid=%b out=%h, want 10 03", rsp_valid, rsp_out);
    end else passed++;
    tick();
    $display("test_back_pressure done");
  endtask

  task automatic test_illegal();
    rsp_ready = 2'b11;
    req_valid = 2'b10; req_control1 = 4'b1111; req_a1 = 8'h12; req_b1 = 8'h34;
    tick();
    req_valid = 2'b00;
    #1;
    total++;
    if ({rsp_valid, rsp_out, rsp_zero, rsp_err, rsp_carry} !== {2'b10, 8'h00, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL illegal: got valid=%b out=%h z=%b e=%b c=%b, want 10 00 1 1 0",
               rsp_valid, rsp_out, rsp_zero, rsp_err, rsp_carry);
    end else passed++;
    tick();
    $display("test_illegal done");
  endtask

  task automatic test_sra_slt();
    rsp_ready = 2'b11;
    req_valid = 2'b01; req_control0 = 4'b0111; req_a0 = 8'h80; req_b0 = 8'd3;
    tick();
    req_control0 = 4'b1000; req_a0 = 8'hFF; req_b0 = 8'h01;
    #1;
    total++;
    if ({rsp_out, rsp_err} !== {8'hF0, 1'b0}) $display("FAIL sra: got out=%h e=%b want f0 0", rsp_out, rsp_err);
    else passed++;
    tick();
    req_valid = 2'b00;
    #1;
    total++;
    if ({rsp_valid, rsp_out} !== {2'b01, 8'h01}) $display("FAIL slt: got valid=%b out=%h want 01 01", rsp_valid, rsp_out);
    else passed++;
    tick();
    $display("test_sra_slt done");
  endtask

  task automatic test_reset_mid_hold();
    rsp_ready = 2'b00;
    req_valid = 2'b01; req_control0 = 4'b0010; req_a0 = 8'd3; req_b0 = 8'd4;
    tick();
    req_valid = 2'b11;
    #1;
    total++;
    if ({rsp_valid, rsp_out} !== {2'b01, 8'd7}) $display("FAIL rmh_held: got valid=%b out=%h want 01 07", rsp_valid, rsp_out);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_out, rsp_carry, rsp_zero, rsp_err} !== 15'd0) begin
      $display("FAIL rmh_async: got ready=%b valid=%b out=%h c=%b z=%b e=%b, want all 0",
               req_ready, rsp_valid, rsp_out, rsp_carry, rsp_zero, rsp_err);
    end else passed++;
    req_valid = 2'b00;
    tick();
    rst = 1'b0;
    rsp_ready = 2'b11;
    tick();
    total++;
    if (rsp_valid !== 2'b00) $display("FAIL rmh_stale: got valid=%b want 00", rsp_valid);
    else passed++;
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) $display("FAIL rmh_first_grant: got %b want 01", req_ready);
    else passed++;
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    $display("test_reset_mid_hold done");
  endtask

  task automatic test_random();
    bit m_held, m_owner, m_last;
    int m_out;
    bit m_carry, m_err;
    bit pend[2];
    int ctrl[2], av[2], bv[2];
    int g, r_out;
    bit r_carry, r_err, drain, can;
    logic [1:0] exp_ready, exp_valid;
    int errs_before;

    do_reset();
    m_held = 1'b0; m_owner = 1'b0; m_last = 1'b1;
    m_out = 0; m_carry = 1'b0; m_err = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom % 3 != 0)) begin
          pend[i] = 1'b1;
          ctrl[i] = $urandom_range(0, 15);
          av[i] = $urandom_range(0, 255);
          bv[i] = ($urandom % 2) ? $urandom_range(0, 9) : $urandom_range(0, 255);
        end
      end
      req_valid = {pend[1], pend[0]};
      req_control0 = 4'(ctrl[0]); req_a0 = 8'(av[0]); req_b0 = 8'(bv[0]);
      req_control1 = 4'(ctrl[1]); req_a1 = 8'(av[1]); req_b1 = 8'(bv[1]);
      rsp_ready = {($urandom % 4 != 0), ($urandom % 4 != 0)};
      #1;
      drain = m_held && rsp_ready[m_owner];
      can = !m_held || drain;
      if (pend[0] && pend[1]) g = m_last ? 0 : 1;
      else if (pend[0]) g = 0;
      else if (pend[1]) g = 1;
      else g = -1;
      exp_ready = (can && g >= 0) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_valid = m_held ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      errs_before = total - passed;
      total++;
      if (req_ready !== exp_ready) $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, req_ready, exp_ready);
      else passed++;
      total++;
      if (rsp_valid !== exp_valid) $display("FAIL rand_valid cyc%0d: got %b want %b", cyc, rsp_valid, exp_valid);
      else passed++;
      if (m_held) begin
        total++;
        if ({rsp_out, rsp_carry, rsp_zero, rsp_err} !== {8'(m_out), m_carry, (m_out == 0), m_err}) begin
          $display("FAIL rand_data cyc%0d: got out=%h c=%b z=%b e=%b want out=%h c=%b z=%b e=%b",
                   cyc, rsp_out, rsp_carry, rsp_zero, rsp_err, 8'(m_out), m_carry, (m_out == 0), m_err);
        end else passed++;
      end
      if (can && g >= 0) begin
        ref_alu(ctrl[g], av[g], bv[g], r_out, r_carry, r_err);
        m_held = 1'b1; m_owner = (g == 1); m_last = (g == 1);
        m_out = r_out; m_carry = r_carry; m_err = r_err;
        pend[g] = 1'b0;
      end else if (drain) begin
        m_held = 1'b0;
      end
      if ((total - passed) != errs_before) $display("random cycle %0d had errors", cyc);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    tick();
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_control0 = 4'd0; req_control1 = 4'd0;
    req_a0 = 8'd0; req_a1 = 8'd0; req_b0 = 8'd0; req_b1 = 8'd0;
    @(negedge clk);
    test_reset();
    test_add_carry();
    test_conflict();
    test_back_pressure();
    test_illegal();
    test_sra_slt();
    test_reset_mid_hold();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
